// File: rtl/seq_control_fsm_if.sv
// Instruction/data memory handshake bundle between the SEQ sequencer (master)
// and the memory subsystem (slave).
interface seq_control_fsm_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  instr,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output instr,
        output dmem_ack
    );
endinterface

// File: rtl/seq_control_fsm.sv
// Multi-cycle sequencer for the SEQ RV32I core: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and owns every PC, IR, regfile and memory enable.
module seq_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    seq_control_fsm_if.master    mem,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [CNT_W-1:0]     instret
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_LINK  = 2'b10;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [6:0]         opcode_q, opcode_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [7:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    logic               imem_req_c;
    logic               dmem_req_c;
    logic               dmem_we_c;
    logic               decode_legal;
    logic               branch_taken;
    logic               is_store;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            funct3_q  <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // BRANCH funct3 010/011 are unassigned encodings and count as illegal.
    always_comb begin
        decode_legal = 1'b0;
        case (opcode_q)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_JAL, OP_JALR, OP_SYSTEM: decode_legal = 1'b1;
            OP_BRANCH:                  decode_legal = (funct3_q[2:1] != 2'b01);
            default:                    decode_legal = 1'b0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3_q)
            3'b000:  branch_taken = alu_zero;
            3'b001:  branch_taken = !alu_zero;
            3'b100:  branch_taken = alu_lt;
            3'b101:  branch_taken = !alu_lt;
            3'b110:  branch_taken = alu_ltu;
            3'b111:  branch_taken = !alu_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    assign is_store = (opcode_q == OP_STORE);

    // The wait counter falls back to zero whenever it is not counting, so every
    // FETCH/MEM entry starts with a fresh budget; an ack on the limit cycle wins.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        wait_d     = '0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ack) begin
                    ir_we    = 1'b1;
                    opcode_d = mem.instr[6:0];
                    funct3_d = mem.instr[14:12];
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_DECODE: begin
                if (decode_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end

            S_EXECUTE: begin
                case (opcode_q)
                    OP_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
                        state_d = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_SYSTEM: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default:   state_d = S_WB;
                endcase
            end

            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (mem.dmem_ack) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                case (opcode_q)
                    OP_LOAD: wb_sel = WB_MEM;
                    OP_JAL: begin
                        wb_sel = WB_LINK;
                        pc_sel = PC_IMM;
                    end
                    OP_JALR: begin
                        wb_sel = WB_LINK;
                        pc_sel = PC_ALU;
                    end
                    default: wb_sel = WB_ALU;
                endcase
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

    // Retirement is defined as the pc_we pulse, so the count cannot drift from it.
    assign instret_d = instret_q + CNT_W'(pc_we);

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

    a_halt_absorbing: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_HALT) |=> (state_q == S_HALT));

    a_single_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_req_c && dmem_req_c));

endmodule

// File: doc/seq_control_fsm.md
# seq_control_fsm

Multi-cycle sequencer for the single-issue SEQ RISC-V core. It drives the PC update path (write enable and next-PC source select), the instruction register load, register-file writeback and the instruction/data memory request handshakes. It walks each RV32I instruction through FETCH, DECODE, EXECUTE, MEM and WB, and it halts on ECALL/EBREAK, on an illegal opcode, or on a memory timeout. It sits beside the PC adder, ALU and register file and owns every enable into them.

## Interface
- MEM_TIMEOUT, 15: maximum number of wait cycles on imem/dmem before a bus error (1..255)
- CNT_W, 32: width of the retired-instruction counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  leave IDLE; sampled only in IDLE
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid on instr
- instr  in  32  fetched instruction word
- dmem_req  out  1  data memory request
- dmem_we  out  1  store (1) or load (0); valid while dmem_req is high
- dmem_ack  in  1  data access complete
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU compare flags, valid in EXECUTE
- ir_we  out  1  load the instruction register
- pc_we  out  1  update the PC
- pc_sel  out  2  next PC: 00 = pc+4, 01 = pc+imm, 10 = ALU result (JALR)
- rf_we  out  1  register-file write
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4
- state  out  3  current state (debug)
- halted, illegal, bus_err  out  1 each  sticky status flags
- instret  out  CNT_W  retired-instruction count

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- All strobe outputs are combinational from the state, the latched opcode/funct3 and the ack inputs. Every strobe is 0 outside the cases listed below.
- IDLE: start=1 moves to FETCH.
- FETCH:
  - imem_req=1 is held until imem_ack.
  - On the ack cycle, ir_we=1, opcode=instr[6:0] and funct3=instr[14:12] are latched internally, and the next state is DECODE.
- DECODE: classify the latched opcode.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 1110011 SYSTEM.
  - Any other opcode, or a BRANCH with funct3 010 or 011, sets illegal=1 and moves to HALT. Otherwise the next state is EXECUTE.
- EXECUTE, BRANCH:
  - Taken condition by funct3: 000 alu_zero, 001 !alu_zero, 100 alu_lt, 101 !alu_lt, 110 alu_ltu, 111 !alu_ltu.
  - Outputs pc_we=1, with pc_sel=01 if taken and 00 otherwise.
  - instret increments; next state is FETCH.
- EXECUTE, LOAD/STORE: next state is MEM.
- EXECUTE, R/I/JAL/JALR: next state is WB.
- EXECUTE, SYSTEM: halted=1, next state is HALT. No PC update and no instret increment.
- MEM:
  - dmem_req=1 is held until dmem_ack; dmem_we=1 for STORE.
  - STORE, on ack: pc_we=1, pc_sel=00, instret increments, next state is FETCH.
  - LOAD, on ack: next state is WB.
- WB: rf_we=1 and pc_we=1, then instret increments and the next state is FETCH.
  - R/I: wb_sel=00, pc_sel=00.
  - LOAD: wb_sel=01, pc_sel=00.
  - JAL: wb_sel=10, pc_sel=01.
  - JALR: wb_sel=10, pc_sel=10.
- HALT: absorbing. Only reset leaves it; start is ignored.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle the request is high and ack is low.
  - When it reaches MEM_TIMEOUT with ack still low, bus_err=1 and the next state is HALT. The request drops, and no ir_we/pc_we is issued.
  - An ack arriving in the same cycle the limit is reached wins: normal transition, no error.
- An ack arriving while the matching request is low is ignored.
- instret wraps modulo 2^CNT_W.
- Exactly one pc_we pulse per retired instruction. No pc_we for illegal, SYSTEM or bus-error terminations.

## Timing
- Reset (async): state=IDLE, wait counter=0, instret=0, halted/illegal/bus_err=0, latched opcode/funct3=0, all strobes 0.
- Reset asserted mid-instruction aborts it immediately: no pc_we/rf_we, and requests drop in the same cycle.
- Minimum cycles per instruction, measured from FETCH entry with ack in the first FETCH cycle:
  - BRANCH: 3
  - R/I/JAL/JALR: 4
  - STORE (ack in first MEM cycle): 4
  - LOAD: 5
- Each wait cycle on imem or dmem adds exactly one cycle.
- instret updates on the clock edge that ends the pc_we cycle.
- Flags update on the edge that enters HALT.

## Test plan
- Reset, start=1, imem_ack immediate, instr=0x00208133 (ADD) -> ir_we at cycle 1; rf_we=1, wb_sel=00, pc_we=1, pc_sel=00 in cycle 4; instret=1.
- BEQ (0x00208463) with alu_zero=1 -> pc_we=1, pc_sel=01 in cycle 3. Repeat with alu_zero=0 -> pc_sel=00.
- LOAD (0x0000A083) with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0; WB has wb_sel=01, rf_we=1; total 8 cycles.
- imem_ack never asserted, MEM_TIMEOUT=15 -> bus_err=1, state=6 after timeout; pc_we never asserted. Second run: ack on the limit cycle -> no error.
- Illegal opcode 0x0000007F -> illegal=1, HALT at the end of DECODE. ECALL 0x00000073 -> halted=1, instret unchanged; later start=1 -> stays in HALT.
- Assert reset during MEM of a STORE -> dmem_req drops the same cycle, state=0, instret keeps no increment for the aborted store.
